// File: rtl/otter_cu_fsm.sv
// otter_cu_fsm: multicycle control unit for the OTTER RV32I core.
// Sequences fetch / execute / writeback / interrupt phases and drives the
// PC, register file, memory and CSR strobes plus the 3-bit PC mux select
// (0=PC+4, 1=JALR, 2=BRANCH, 3=JAL, 4=MTVEC).
// Build option: define OTTER_CU_INTR_EN to build the interrupt-entry state;
// left undefined, intr is ignored, int_taken is 0 and pc_source never
// reaches MTVEC.
module otter_cu_fsm #(
  parameter int unsigned INIT_CYCLES = 1  // cycles of PC reset after RST release, 1..15
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       intr,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       br_eq,
  input  logic       br_lt,
  input  logic       br_ltu,
  output logic       reset,
  output logic       pc_write,
  output logic       reg_write,
  output logic       mem_rden1,
  output logic       mem_rden2,
  output logic       mem_we2,
  output logic       csr_we,
  output logic       int_taken,
  output logic [2:0] pc_source
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3
`ifdef OTTER_CU_INTR_EN
    ,
    ST_INTR  = 3'd4
`endif
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_CSRRW   = 3'b001;

  localparam logic [2:0] PCSRC_PC4    = 3'd0;
  localparam logic [2:0] PCSRC_JALR   = 3'd1;
  localparam logic [2:0] PCSRC_BRANCH = 3'd2;
  localparam logic [2:0] PCSRC_JAL    = 3'd3;
`ifdef OTTER_CU_INTR_EN
  localparam logic [2:0] PCSRC_MTVEC  = 3'd4;
`endif

  localparam logic [3:0] INIT_LAST = 4'(INIT_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] init_cnt_q, init_cnt_d;
  logic       br_taken;
  logic       intr_req;

`ifdef OTTER_CU_INTR_EN
  assign intr_req = intr;
`else
  logic unused_intr;
  assign unused_intr = intr;
  assign intr_req    = 1'b0;
`endif

  // State and INIT counter register; RST forces INIT asynchronously.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  // Branch condition select from func3.
  always_comb begin
    br_taken = 1'b0;
    case (func3)
      3'b000:  br_taken = br_eq;
      3'b001:  br_taken = !br_eq;
      3'b100:  br_taken = br_lt;
      3'b101:  br_taken = !br_lt;
      3'b110:  br_taken = br_ltu;
      3'b111:  br_taken = !br_ltu;
      default: br_taken = 1'b0;
    endcase
  end

  // Next-state and strobe decode.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = '0;
    reset      = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_rden1  = 1'b0;
    mem_rden2  = 1'b0;
    mem_we2    = 1'b0;
    csr_we     = 1'b0;
    int_taken  = 1'b0;
    pc_source  = PCSRC_PC4;

    case (state_q)
      ST_INIT: begin
        reset = 1'b1;
        if (init_cnt_q >= INIT_LAST) begin
          state_d = ST_FETCH;
        end else begin
          init_cnt_d = init_cnt_q + 4'd1;
        end
      end

      ST_FETCH: begin
        mem_rden1 = 1'b1;
        state_d   = ST_EXEC;
      end

      ST_EXEC: begin
        state_d  = intr_req ? state_t'(3'd4) : ST_FETCH;
        pc_write = 1'b1;
        case (opcode)
          OPC_LUI, OPC_AUIPC, OPC_OP_IMM, OPC_OP: begin
            reg_write = 1'b1;
          end
          OPC_JAL: begin
            reg_write = 1'b1;
            pc_source = PCSRC_JAL;
          end
          OPC_JALR: begin
            reg_write = 1'b1;
            pc_source = PCSRC_JALR;
          end
          OPC_BRANCH: begin
            pc_source = br_taken ? PCSRC_BRANCH : PCSRC_PC4;
          end
          OPC_STORE: begin
            mem_we2 = 1'b1;
          end
          OPC_LOAD: begin
            // PC advances in WB, and intr is deliberately not sampled here.
            pc_write  = 1'b0;
            mem_rden2 = 1'b1;
            state_d   = ST_WB;
          end
          OPC_SYSTEM: begin
            if (func3 == F3_CSRRW) begin
              reg_write = 1'b1;
              csr_we    = 1'b1;
            end
          end
          default: begin
            // Illegal instruction retires as a NOP.
          end
        endcase
      end

      ST_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        state_d   = intr_req ? state_t'(3'd4) : ST_FETCH;
      end

`ifdef OTTER_CU_INTR_EN
      ST_INTR: begin
        int_taken = 1'b1;
        pc_write  = 1'b1;
        pc_source = PCSRC_MTVEC;
        state_d   = ST_FETCH;
      end
`endif

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Strobe exclusivity invariants.
  a_pcw_fetch_excl : assert property (@(posedge CLK) disable iff (RST)
    !(pc_write && mem_rden1));
  a_mem_rw_excl : assert property (@(posedge CLK) disable iff (RST)
    !(mem_we2 && mem_rden2));

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Self-checking bench for otter_cu_fsm: directed scenarios plus a random
// instruction stream checked against an instruction-level reference model.
module tb_otter_cu_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       intr = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic       br_eq = 1'b0, br_lt = 1'b0, br_ltu = 1'b0;
  logic       reset, pc_write, reg_write, mem_rden1, mem_rden2, mem_we2;
  logic       csr_we, int_taken;
  logic [2:0] pc_source;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  otter_cu_fsm #(.INIT_CYCLES(1)) dut (
    .CLK(CLK), .RST(RST), .intr(intr), .opcode(opcode), .func3(func3),
    .br_eq(br_eq), .br_lt(br_lt), .br_ltu(br_ltu),
    .reset(reset), .pc_write(pc_write), .reg_write(reg_write),
    .mem_rden1(mem_rden1), .mem_rden2(mem_rden2), .mem_we2(mem_we2),
    .csr_we(csr_we), .int_taken(int_taken), .pc_source(pc_source)
  );

  always #5 CLK = ~CLK;

  // Output vector: {reset,pc_write,reg_write,rden1,rden2,we2,csr_we,int_taken,pc_source}
  function automatic logic [10:0] ev(input bit rst, input bit pcw, input bit rw,
                                     input bit r1, input bit r2, input bit we,
                                     input bit csr, input bit it, input logic [2:0] src);
    return {rst, pcw, rw, r1, r2, we, csr, it, src};
  endfunction

  function automatic logic [10:0] obs();
    return {reset, pc_write, reg_write, mem_rden1, mem_rden2, mem_we2,
            csr_we, int_taken, pc_source};
  endfunction

  localparam logic [10:0] V_INIT  = 11'b1_0_0_0_0_0_0_0_000;
  localparam logic [10:0] V_FETCH = 11'b0_0_0_1_0_0_0_0_000;
  localparam logic [10:0] V_WB    = 11'b0_1_1_0_0_0_0_0_000;
  localparam logic [10:0] V_INTR  = 11'b0_1_0_0_0_0_0_1_100;

  // Reference: strobes an instruction produces in its execute cycle.
  function automatic logic [10:0] exec_model(input logic [6:0] opc, input logic [2:0] f3,
                                             input bit eq, input bit lt, input bit ltu);
    bit cond, taken;
    case (opc)
      7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011: return ev(0,1,1,0,0,0,0,0,3'd0);
      7'b1101111: return ev(0,1,1,0,0,0,0,0,3'd3);
      7'b1100111: return ev(0,1,1,0,0,0,0,0,3'd1);
      7'b1100011: begin
        case (f3[2:1])
          2'd0:    cond = eq;
          2'd2:    cond = lt;
          2'd3:    cond = ltu;
          default: cond = 1'b0;
        endcase
        taken = (f3[2:1] != 2'd1) && (cond ^ f3[0]);
        return ev(0,1,0,0,0,0,0,0, taken ? 3'd2 : 3'd0);
      end
      7'b0100011: return ev(0,1,0,0,0,1,0,0,3'd0);
      7'b0000011: return ev(0,0,0,0,1,0,0,0,3'd0);
      7'b1110011: return (f3 == 3'b001) ? ev(0,1,1,0,0,0,1,0,3'd0)
                                        : ev(0,1,0,0,0,0,0,0,3'd0);
      default:    return ev(0,1,0,0,0,0,0,0,3'd0);
    endcase
  endfunction

  // Applies inputs for one cycle, samples outputs mid-cycle, advances past the edge.
  task automatic cycle(input logic [6:0] opc, input logic [2:0] f3, input bit eq,
                       input bit lt, input bit ltu, input bit ii, output logic [10:0] o);
    opcode = opc; func3 = f3; br_eq = eq; br_lt = lt; br_ltu = ltu; intr = ii;
    @(negedge CLK);
    o = obs();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] o;
    #1 RST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      vectors++;
      if (obs() !== V_INIT) begin
        miscompares++;
        $display("FAIL reset_held[%0d]: got %b expected %b", i, obs(), V_INIT);
      end
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    cycle(7'h00, 3'd0, 0, 0, 0, 0, o);
    vectors++;
    if (o !== V_INIT) begin
      miscompares++;
      $display("FAIL reset_init_cycle: got %b expected %b", o, V_INIT);
    end
    cycle(7'h00, 3'd0, 0, 0, 0, 0, o);
    vectors++;
    if (o !== V_FETCH) begin
      miscompares++;
      $display("FAIL reset_first_fetch: got %b expected %b", o, V_FETCH);
    end
    cycle(7'b0010011, 3'd0, 0, 0, 0, 0, o);
    vectors++;
    if (o !== ev(0,1,1,0,0,0,0,0,3'd0)) begin
      miscompares++;
      $display("FAIL reset_first_exec: got %b expected %b", o, ev(0,1,1,0,0,0,0,0,3'd0));
    end
  endtask

  task automatic test_branch();
    logic [10:0] o;
    logic [2:0]  f3s [3] = '{3'b101, 3'b101, 3'b010};
    bit          lts [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  src [3] = '{3'd2, 3'd0, 3'd0};
    for (int i = 0; i < 3; i++) begin
      cycle(7'h55, 3'd7, 1, 1, 1, 0, o);
      vectors++;
      if (o !== V_FETCH) begin
        miscompares++;
        $display("FAIL branch_fetch[%0d]: got %b expected %b", i, o, V_FETCH);
      end
      cycle(7'b1100011, f3s[i], 0, lts[i], 0, 0, o);
      vectors++;
      if (o !== ev(0,1,0,0,0,0,0,0,src[i])) begin
        miscompares++;
        $display("FAIL branch_exec[%0d]: got %b expected %b", i, o, ev(0,1,0,0,0,0,0,0,src[i]));
      end
    end
  endtask

  task automatic test_load();
    logic [10:0] o;
    cycle(7'h00, 3'd0, 0, 0, 0, 1, o);
    vectors++;
    if (o !== V_FETCH) begin
      miscompares++;
      $display("FAIL load_fetch: got %b expected %b", o, V_FETCH);
    end
    cycle(7'b0000011, 3'd2, 0, 0, 0, 1, o);
    vectors++;
    if (o !== ev(0,0,0,0,1,0,0,0,3'd0)) begin
      miscompares++;
      $display("FAIL load_exec: got %b expected %b", o, ev(0,0,0,0,1,0,0,0,3'd0));
    end
    cycle(7'b0000011, 3'd2, 0, 0, 0, 0, o);
    vectors++;
    if (o !== V_WB) begin
      miscompares++;
      $display("FAIL load_wb: got %b expected %b", o, V_WB);
    end
    cycle(7'h00, 3'd0, 0, 0, 0, 0, o);
    vectors++;
    if (o !== V_FETCH) begin
      miscompares++;
      $display("FAIL load_next_fetch: got %b expected %b", o, V_FETCH);
    end
    cycle(7'b0010011, 3'd0, 0, 0, 0, 0, o);
  endtask

  task automatic test_interrupt();
    logic [10:0] o;
    cycle(7'h00, 3'd0, 0, 0, 0, 0, o);
    cycle(7'b0110011, 3'd0, 0, 0, 0, 1, o);
    vectors++;
    if (o !== ev(0,1,1,0,0,0,0,0,3'd0)) begin
      miscompares++;
      $display("FAIL intr_exec: got %b expected %b", o, ev(0,1,1,0,0,0,0,0,3'd0));
    end
`ifdef OTTER_CU_INTR_EN
    cycle(7'b0110011, 3'd0, 0, 0, 0, 1, o);
    vectors++;
    if (o !== V_INTR) begin
      miscompares++;
      $display("FAIL intr_entry: got %b expected %b", o, V_INTR);
    end
    cycle(7'h00, 3'd0, 0, 0, 0, 1, o);
`else
    cycle(7'h00, 3'd0, 0, 0, 0, 1, o);
`endif
    vectors++;
    if (o !== V_FETCH) begin
      miscompares++;
      $display("FAIL intr_then_fetch: got %b expected %b", o, V_FETCH);
    end
    cycle(7'b0010011, 3'd0, 0, 0, 0, 0, o);
  endtask

  task automatic test_csr_illegal();
    logic [10:0] o;
    cycle(7'h00, 3'd0, 0, 0, 0, 0, o);
    cycle(7'b1110011, 3'b001, 0, 0, 0, 0, o);
    vectors++;
    if (o !== ev(0,1,1,0,0,0,1,0,3'd0)) begin
      miscompares++;
      $display("FAIL csrrw_exec: got %b expected %b", o, ev(0,1,1,0,0,0,1,0,3'd0));
    end
    cycle(7'h00, 3'd0, 0, 0, 0, 0, o);
    cycle(7'b1111111, 3'b001, 1, 1, 1, 0, o);
    vectors++;
    if (o !== ev(0,1,0,0,0,0,0,0,3'd0)) begin
      miscompares++;
      $display("FAIL illegal_exec: got %b expected %b", o, ev(0,1,0,0,0,0,0,0,3'd0));
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] o;
    cycle(7'h00, 3'd0, 0, 0, 0, 0, o);
    cycle(7'b0000011, 3'd0, 0, 0, 0, 0, o);
    #2;
    vectors++;
    if (obs() !== V_WB) begin
      miscompares++;
      $display("FAIL midrst_before: got %b expected %b", obs(), V_WB);
    end
    RST = 1'b1;
    #1;
    vectors++;
    if (obs() !== V_INIT) begin
      miscompares++;
      $display("FAIL midrst_async: got %b expected %b", obs(), V_INIT);
    end
    @(posedge CLK);
    #1 RST = 1'b0;
    cycle(7'h00, 3'd0, 0, 0, 0, 0, o);
    vectors++;
    if (o !== V_INIT) begin
      miscompares++;
      $display("FAIL midrst_init: got %b expected %b", o, V_INIT);
    end
  endtask

  task automatic test_random();
    logic [10:0] o, e;
    logic [6:0]  opcs [12] = '{7'b0110111, 7'b0010111, 7'b0010011, 7'b0110011,
                               7'b1101111, 7'b1100111, 7'b1100011, 7'b0100011,
                               7'b0000011, 7'b1110011, 7'b0000000, 7'b1011011};
    for (int n = 0; n < 400; n++) begin
      logic [6:0] opc;
      logic [2:0] f3;
      bit eq, lt, ltu, ie, iw, last_i;
      opc = opcs[$urandom_range(0, 11)];
      if ($urandom_range(0, 15) == 0) opc = 7'($urandom);
      f3  = 3'($urandom);
      eq  = 1'($urandom); lt = 1'($urandom); ltu = 1'($urandom);
      ie  = ($urandom_range(0, 9) < 3);
      iw  = ($urandom_range(0, 9) < 3);
      cycle(7'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            1'($urandom), o);
      vectors++;
      if (o !== V_FETCH) begin
        miscompares++;
        $display("FAIL rnd_fetch[%0d]: got %b expected %b", n, o, V_FETCH);
      end
      e = exec_model(opc, f3, eq, lt, ltu);
      cycle(opc, f3, eq, lt, ltu, ie, o);
      vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL rnd_exec[%0d] opc=%b f3=%b: got %b expected %b", n, opc, f3, o, e);
      end
      last_i = ie;
      if (opc == 7'b0000011) begin
        cycle(opc, f3, eq, lt, ltu, iw, o);
        vectors++;
        if (o !== V_WB) begin
          miscompares++;
          $display("FAIL rnd_wb[%0d]: got %b expected %b", n, o, V_WB);
        end
        last_i = iw;
      end
`ifdef OTTER_CU_INTR_EN
      if (last_i) begin
        cycle(opc, f3, eq, lt, ltu, 1'($urandom), o);
        vectors++;
        if (o !== V_INTR) begin
          miscompares++;
          $display("FAIL rnd_intr[%0d]: got %b expected %b", n, o, V_INTR);
        end
      end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_load();
    test_interrupt();
    test_csr_illegal();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Runaway guard so the bench always ends with a summary.
  initial begin
    #200000;
    miscompares++;
    $display("FAIL timeout: got no completion expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
